keypad_code_lock: RTL and testbench

Parametrised keypad lock core for the SSD digital-lock design. It scans a 4x4 matrix keypad, debounces key presses, and collects an N-digit entry buffer that the seven-segment display path shows. The entered code is checked against a reprogrammable stored code, and the block enforces a retry limit with a timed lockout. It replaces the fixed 4-digit lock logic inside the top level; the display multiplexer consumes `digits` and `digit_cnt`.

---
 rtl/keypad_lock_pkg.sv | 46 ++++
 rtl/keypad_scanner.sv | 114 +++++++++++
 rtl/keypad_code_lock.sv | 168 ++++++++++++++++
 tb/tb_keypad_code_lock.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_lock_pkg.sv
// Shared types and key definitions for the keypad code lock.
// Contents:
//   state_t  - lock FSM states
//   KEY_*    - codes of the non-digit keys
//   keymap() - (row, column) position on the 4x4 keypad -> key code
package keypad_lock_pkg;

    typedef enum logic [1:0] {
        ST_ENTRY,
        ST_CHECK,
        ST_OPEN,
        ST_LOCKOUT
    } state_t;

    localparam logic [3:0] KEY_A    = 4'hA;
    localparam logic [3:0] KEY_B    = 4'hB;
    localparam logic [3:0] KEY_C    = 4'hC;
    localparam logic [3:0] KEY_D    = 4'hD;
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    // Rows top to bottom: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
    function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = KEY_A;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = KEY_B;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = KEY_C;
            4'hC: code = KEY_STAR;
            4'hD: code = 4'h0;
            4'hE: code = KEY_HASH;
            default: code = KEY_D;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with ghost rejection and debounce.
// Ports:
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   i_row          - keypad rows, active-low
//   o_col          - column drive, one-hot active-low
//   o_key_valid    - one-cycle strobe on an accepted press
//   o_key_code     - code of the last accepted key
module keypad_scanner
    import keypad_lock_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 50_000,
    parameter int unsigned DEBOUNCE_SCANS = 20
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_row,
    output logic [3:0] o_col,
    output logic       o_key_valid,
    output logic [3:0] o_key_code
);

    localparam logic [31:0] LP_DIV_LAST = 32'(SCAN_DIV - 1);
    localparam logic [15:0] LP_DEB      = 16'(DEBOUNCE_SCANS);

    logic [31:0] r_div;
    logic [1:0]  r_col_idx;
    logic [1:0]  r_acc_n;      // keys seen so far this scan, saturates at 2
    logic [3:0]  r_acc_code;
    logic [4:0]  r_prev_res;   // {valid, code}; all-zero means "none"
    logic [15:0] r_stable;
    logic        r_released;
    logic        r_key_valid;
    logic [3:0]  r_key_code;

    logic        w_sample;
    logic [3:0]  w_pressed;
    logic [1:0]  w_col_n;
    logic [1:0]  w_col_row;
    logic [2:0]  w_sum_n;
    logic [1:0]  w_tot_n;
    logic [3:0]  w_code;
    logic [4:0]  w_res;
    logic [15:0] w_stable_nxt;
    logic        w_settled;
    logic        w_accept;

    assign w_sample  = (r_div == LP_DIV_LAST);
    assign w_pressed = ~i_row;

    always_comb begin
        w_col_n   = '0;
        w_col_row = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (w_pressed[i]) begin
                if (w_col_n != 2'd2) w_col_n = w_col_n + 2'd1;
                w_col_row = 2'(i);
            end
        end
    end

    // Key count over the whole scan so far, including this slot; any count
    // other than exactly one makes the scan result "none".
    assign w_sum_n      = {1'b0, r_acc_n} + {1'b0, w_col_n};
    assign w_tot_n      = (w_sum_n >= 3'd2) ? 2'd2 : w_sum_n[1:0];
    assign w_code       = (w_col_n == 2'd1) ? keymap(w_col_row, r_col_idx) : r_acc_code;
    assign w_res        = (w_tot_n == 2'd1) ? {1'b1, w_code} : 5'd0;
    assign w_stable_nxt = (w_res != r_prev_res) ? '0 :
                          (r_stable == LP_DEB) ? r_stable : r_stable + 16'd1;
    assign w_settled    = (w_stable_nxt >= LP_DEB);
    assign w_accept     = w_res[4] && w_settled && r_released;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div       <= '0;
            r_col_idx   <= '0;
            r_acc_n     <= '0;
            r_acc_code  <= '0;
            r_prev_res  <= '0;
            r_stable    <= '0;
            r_released  <= 1'b1;
            r_key_valid <= 1'b0;
            r_key_code  <= '0;
        end else begin
            r_key_valid <= 1'b0;
            if (w_sample) begin
                r_div     <= '0;
                r_col_idx <= r_col_idx + 2'd1;
                if (r_col_idx == 2'd3) begin
                    r_acc_n    <= '0;
                    r_acc_code <= '0;
                    r_prev_res <= w_res;
                    r_stable   <= w_stable_nxt;
                    if (w_accept) begin
                        r_key_valid <= 1'b1;
                        r_key_code  <= w_res[3:0];
                        r_released  <= 1'b0;
                    end else if (!w_res[4] && w_settled) begin
                        r_released  <= 1'b1;
                    end
                end else begin
                    r_acc_n    <= w_tot_n;
                    r_acc_code <= w_code;
                end
            end else begin
                r_div <= r_div + 32'd1;
            end
        end
    end

    assign o_col       = ~(4'b0001 << r_col_idx);
    assign o_key_valid = r_key_valid;
    assign o_key_code  = r_key_code;

endmodule

// File: rtl/keypad_code_lock.sv
// Keypad code lock: entry buffer, stored code, retry limit and timed lockout.
// Ports:
//   pulse_50Mhz, rst_n  - clock, asynchronous active-low reset
//   row / col           - keypad matrix (active-low)
//   key_valid, key_code - accepted key strobe and code
//   digits, digit_cnt   - entry buffer (newest digit in nibble 0) and count
//   unlocked            - high while open
//   locked_out          - high during lockout
//   fail, code_saved    - one-cycle strobes
module keypad_code_lock
    import keypad_lock_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned SCAN_DIV       = 50_000,
    parameter int unsigned DEBOUNCE_SCANS = 20,
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 500_000_000,
    parameter logic [4*NUM_DIGITS-1:0] DEFAULT_CODE = (4*NUM_DIGITS)'(32'h1234)
) (
    input  logic                    pulse_50Mhz,
    input  logic                    rst_n,
    input  logic [3:0]              row,
    output logic [3:0]              col,
    output logic                    key_valid,
    output logic [3:0]              key_code,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [3:0]              digit_cnt,
    output logic                    unlocked,
    output logic                    locked_out,
    output logic                    fail,
    output logic                    code_saved
);

    localparam int unsigned DW            = 4 * NUM_DIGITS;
    localparam logic [3:0]  LP_N          = 4'(NUM_DIGITS);
    localparam logic [7:0]  LP_MAX_TRIES  = 8'(MAX_TRIES);
    localparam logic [31:0] LP_LOCK_LAST  = 32'(LOCKOUT_CYCLES - 1);

    state_t        r_state,    w_state_nxt;
    logic [DW-1:0] r_digits,   w_digits_nxt;
    logic [DW-1:0] r_code,     w_code_nxt;
    logic [3:0]    r_cnt,      w_cnt_nxt;
    logic [7:0]    r_tries,    w_tries_nxt;
    logic [31:0]   r_lock_cnt, w_lock_nxt;
    logic          r_fail,     w_fail_nxt;
    logic          r_saved,    w_saved_nxt;

    logic          w_key_valid;
    logic [3:0]    w_key_code;
    logic          w_strobe;
    logic          w_full;
    logic [DW-1:0] w_shifted;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_scanner (
        .i_clk       (pulse_50Mhz),
        .i_rst_n     (rst_n),
        .i_row       (row),
        .o_col       (col),
        .o_key_valid (w_key_valid),
        .o_key_code  (w_key_code)
    );

    // Lockout blinds the FSM to keys; the scanner keeps debouncing.
    assign w_strobe  = w_key_valid && (r_state != ST_LOCKOUT);
    assign w_full    = (r_cnt == LP_N);
    assign w_shifted = (r_digits << 4) | DW'(w_key_code);

    always_comb begin
        w_state_nxt  = r_state;
        w_digits_nxt = r_digits;
        w_code_nxt   = r_code;
        w_cnt_nxt    = r_cnt;
        w_tries_nxt  = r_tries;
        w_lock_nxt   = r_lock_cnt;
        w_fail_nxt   = 1'b0;
        w_saved_nxt  = 1'b0;
        case (r_state)
            ST_ENTRY, ST_OPEN: begin
                if (w_strobe) begin
                    if (w_key_code <= 4'd9) begin
                        if (!w_full) begin
                            w_digits_nxt = w_shifted;
                            w_cnt_nxt    = r_cnt + 4'd1;
                        end
                    end else if (w_key_code == KEY_STAR) begin
                        w_digits_nxt = '0;
                        w_cnt_nxt    = '0;
                    end else if (r_state == ST_ENTRY) begin
                        if (w_key_code == KEY_HASH) w_state_nxt = ST_CHECK;
                    end else if (w_key_code == KEY_A) begin
                        if (w_full) begin
                            w_code_nxt   = r_digits;
                            w_saved_nxt  = 1'b1;
                            w_digits_nxt = '0;
                            w_cnt_nxt    = '0;
                        end
                    end else if (w_key_code == KEY_HASH || w_key_code == KEY_D) begin
                        w_digits_nxt = '0;
                        w_cnt_nxt    = '0;
                        w_state_nxt  = ST_ENTRY;
                    end
                end
            end
            ST_CHECK: begin
                w_digits_nxt = '0;
                w_cnt_nxt    = '0;
                if (w_full && (r_digits == r_code)) begin
                    w_state_nxt = ST_OPEN;
                    w_tries_nxt = '0;
                end else begin
                    w_fail_nxt  = 1'b1;
                    w_tries_nxt = r_tries + 8'd1;
                    if ((r_tries + 8'd1) == LP_MAX_TRIES) begin
                        w_state_nxt = ST_LOCKOUT;
                        w_lock_nxt  = '0;
                    end else begin
                        w_state_nxt = ST_ENTRY;
                    end
                end
            end
            ST_LOCKOUT: begin
                if (r_lock_cnt == LP_LOCK_LAST) begin
                    w_state_nxt = ST_ENTRY;
                    w_tries_nxt = '0;
                    w_lock_nxt  = '0;
                end else begin
                    w_lock_nxt  = r_lock_cnt + 32'd1;
                end
            end
            default: w_state_nxt = ST_ENTRY;
        endcase
    end

    always_ff @(posedge pulse_50Mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_ENTRY;
            r_digits   <= '0;
            r_code     <= DEFAULT_CODE;
            r_cnt      <= '0;
            r_tries    <= '0;
            r_lock_cnt <= '0;
            r_fail     <= 1'b0;
            r_saved    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_digits   <= w_digits_nxt;
            r_code     <= w_code_nxt;
            r_cnt      <= w_cnt_nxt;
            r_tries    <= w_tries_nxt;
            r_lock_cnt <= w_lock_nxt;
            r_fail     <= w_fail_nxt;
            r_saved    <= w_saved_nxt;
        end
    end

    assign key_valid  = w_key_valid;
    assign key_code   = w_key_code;
    assign digits     = r_digits;
    assign digit_cnt  = r_cnt;
    assign unlocked   = (r_state == ST_OPEN);
    assign locked_out = (r_state == ST_LOCKOUT);
    assign fail       = r_fail;
    assign code_saved = r_saved;

endmodule

// File: tb/tb_keypad_code_lock.sv
module tb_keypad_code_lock;

    localparam int SD   = 4;
    localparam int DEB  = 2;
    localparam int MAXT = 3;
    localparam int LOCK = 100;
    localparam int N    = 4;
    localparam int SCAN = 4 * SD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] digits;
    logic [3:0]  digit_cnt;
    logic        unlocked, locked_out, fail, code_saved;

    // Physical keypad: bit r*4+c set means the key at row r, column c is held.
    logic [15:0] mask;
    int          keytab [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    int n_checks = 0;
    int n_pass   = 0;
    int kv_cnt = 0, fail_cnt = 0, saved_cnt = 0;

    keypad_code_lock #(
        .NUM_DIGITS     (N),
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DEB),
        .MAX_TRIES      (MAXT),
        .LOCKOUT_CYCLES (LOCK),
        .DEFAULT_CODE   (16'h1234)
    ) dut (
        .pulse_50Mhz (clk),
        .rst_n       (rst_n),
        .row         (row),
        .col         (col),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .digits      (digits),
        .digit_cnt   (digit_cnt),
        .unlocked    (unlocked),
        .locked_out  (locked_out),
        .fail        (fail),
        .code_saved  (code_saved)
    );

    always #5 clk = ~clk;

    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (col[c] == 1'b0 && mask[r*4+c]) row[r] = 1'b0;
    end

    // ---------------- behavioural model ----------------
    int  m_cyc, m_samp_n, m_samp_code, m_prev, m_run, m_tries, m_lock_left, m_kc, m_code_val;
    bit  m_released, m_kv, m_open, m_pending, m_fail, m_saved;
    int  m_buf[$];

    function automatic int buf_val();
        int v = 0;
        foreach (m_buf[i]) v = v * 16 + m_buf[i];
        return v;
    endfunction

    task automatic model_init();
        m_cyc = 0; m_samp_n = 0; m_samp_code = 0; m_prev = -1; m_run = 1;
        m_released = 1; m_kv = 0; m_kc = 0; m_buf.delete(); m_code_val = 'h1234;
        m_open = 0; m_lock_left = 0; m_pending = 0; m_tries = 0; m_fail = 0; m_saved = 0;
    endtask

    task automatic model_step();
        bit kv;
        int kc, c, res;
        bit new_kv;
        kv = m_kv; kc = m_kc;
        m_fail = 0; m_saved = 0;
        if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) m_tries = 0;
        end else if (m_pending) begin
            m_pending = 0;
            if (m_buf.size() == N && buf_val() == m_code_val) begin
                m_open = 1; m_tries = 0;
            end else begin
                m_fail = 1; m_tries++;
                if (m_tries == MAXT) m_lock_left = LOCK;
            end
            m_buf.delete();
        end else if (kv) begin
            if (kc <= 9) begin
                if (m_buf.size() < N) m_buf.push_back(kc);
            end else if (kc == 14) begin
                m_buf.delete();
            end else if (m_open) begin
                if (kc == 10 && m_buf.size() == N) begin
                    m_code_val = buf_val(); m_saved = 1; m_buf.delete();
                end else if (kc == 15 || kc == 13) begin
                    m_buf.delete(); m_open = 0;
                end
            end else if (kc == 15) begin
                m_pending = 1;
            end
        end
        new_kv = 0;
        if (m_cyc % SD == SD - 1) begin
            c = (m_cyc / SD) % 4;
            for (int r = 0; r < 4; r++)
                if (mask[r*4+c]) begin m_samp_n++; m_samp_code = keytab[r*4+c]; end
            if (c == 3) begin
                res = (m_samp_n == 1) ? m_samp_code : -1;
                if (res == m_prev) m_run++; else m_run = 1;
                m_prev = res;
                if (res >= 0 && m_run - 1 >= DEB && m_released) begin
                    new_kv = 1; m_kc = res; m_released = 0;
                end
                if (res < 0 && m_run - 1 >= DEB) m_released = 1;
                m_samp_n = 0;
            end
        end
        m_kv = new_kv;
        m_cyc++;
    endtask

    initial begin
        model_init();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_init();
            else model_step();
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    initial begin
        logic [3:0] ec;
        forever begin
            @(negedge clk);
            ec = 4'hF;
            ec[(m_cyc / SD) % 4] = 1'b0;
            chk("col", col, ec);
            chk("key_valid", key_valid, m_kv);
            chk("key_code", key_code, m_kc);
            chk("digits", digits, buf_val());
            chk("digit_cnt", digit_cnt, m_buf.size());
            chk("unlocked", unlocked, m_open);
            chk("locked_out", locked_out, m_lock_left > 0);
            chk("fail", fail, m_fail);
            chk("code_saved", code_saved, m_saved);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (key_valid === 1'b1)  kv_cnt++;
                if (fail === 1'b1)       fail_cnt++;
                if (code_saved === 1'b1) saved_cnt++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int idx_of(input int code);
        for (int i = 0; i < 16; i++) if (keytab[i] == code) return i;
        return 0;
    endfunction

    function automatic int char_code(input byte ch);
        if (ch >= "0" && ch <= "9") return ch - "0";
        case (ch)
            "*": return 14;
            "#": return 15;
            "A": return 10;
            "B": return 11;
            "C": return 12;
            default: return 13;
        endcase
    endfunction

    task automatic tap(input int code);
        int idx;
        idx = idx_of(code);
        if ($urandom_range(0, 1) == 1) begin
            for (int g = 0; g < 2; g++) begin
                mask[idx] = 1'b1; wait_cyc($urandom_range(1, 3));
                mask[idx] = 1'b0; wait_cyc($urandom_range(1, 3));
            end
        end
        mask[idx] = 1'b1;
        wait_cyc(SCAN * $urandom_range(4, 6));
        mask[idx] = 1'b0;
        wait_cyc(SCAN * $urandom_range(4, 6));
    endtask

    task automatic type_str(input string s);
        for (int i = 0; i < s.len(); i++) tap(char_code(s[i]));
    endtask

    // Hold '#' until the scanner strobes it; got=0 if it never does.
    task automatic hold_hash(output bit got);
        got = 0;
        mask[idx_of(15)] = 1'b1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) got = 1;
        end
    endtask

    initial begin
        int b_kv, b_fail, b_saved, i1, i2;
        bit got;
        mask  = '0;
        rst_n = 1'b0;
        wait_cyc(3);
        chk("rst_col", col, 4'b1110);
        chk("rst_digits", digits, 16'h0);
        chk("rst_unlocked", unlocked, 1'b0);
        rst_n = 1'b1;
        wait_cyc(SCAN * 4);

        // Long hold of key 5 gives a single strobe
        b_kv = kv_cnt;
        mask[idx_of(5)] = 1'b1; wait_cyc(SCAN * 10);
        mask[idx_of(5)] = 1'b0; wait_cyc(SCAN * 6);
        chk("hold5_strobes", kv_cnt - b_kv, 1);
        chk("hold5_code", key_code, 4'h5);
        chk("hold5_digits", digits, 16'h0005);
        chk("hold5_cnt", digit_cnt, 4'd1);
        type_str("*");

        // Correct default code
        b_fail = fail_cnt;
        type_str("1234#");
        chk("open_unlocked", unlocked, 1'b1);
        chk("open_no_fail", fail_cnt - b_fail, 0);
        type_str("D");
        chk("leave_open", unlocked, 1'b0);

        // Three failures -> lockout; a key strobed during lockout is dropped
        b_fail = fail_cnt;
        type_str("9999#9999#9999");
        hold_hash(got);
        chk("hash_strobe_seen", got, 1'b1);
        mask[idx_of(7)] = 1'b1;          // two keys: scans read "none"
        repeat (48) @(posedge clk);
        #1;
        chk("lockout_high", locked_out, 1'b1);
        mask[idx_of(15)] = 1'b0;         // 7 alone strobes near the end of lockout
        wait_cyc(SCAN * 4);
        mask[idx_of(7)] = 1'b0;
        wait_cyc(SCAN * 6);
        chk("lockout_fails", fail_cnt - b_fail, 3);
        chk("lockout_over", locked_out, 1'b0);
        chk("lockout_key_ignored", digit_cnt, 4'd0);
        b_fail = fail_cnt;
        type_str("9999#");
        chk("tries_cleared_fail", fail_cnt - b_fail, 1);
        chk("tries_cleared_nolock", locked_out, 1'b0);

        // Reprogram the code while open
        type_str("1234#");
        b_saved = saved_cnt;
        type_str("5678A");
        chk("saved_pulse", saved_cnt - b_saved, 1);
        chk("model_code", m_code_val, 'h5678);
        type_str("D");
        chk("closed_after_D", unlocked, 1'b0);
        b_fail = fail_cnt;
        type_str("1234#");
        chk("old_code_fails", fail_cnt - b_fail, 1);
        type_str("5678#");
        chk("new_code_opens", unlocked, 1'b1);
        type_str("D");

        // Buffer limit, clear, short code
        type_str("12345");
        chk("full_cnt", digit_cnt, 4'd4);
        chk("full_digits", digits, 16'h1234);
        type_str("*");
        chk("star_digits", digits, 16'h0);
        chk("star_cnt", digit_cnt, 4'd0);
        b_fail = fail_cnt;
        type_str("12#");
        chk("short_fail", fail_cnt - b_fail, 1);

        // Ghost: two keys together never strobe
        b_kv = kv_cnt;
        mask[idx_of(1)] = 1'b1; mask[idx_of(2)] = 1'b1;
        wait_cyc(SCAN * 6);
        mask = '0;
        wait_cyc(SCAN * 6);
        chk("ghost_no_strobe", kv_cnt - b_kv, 0);

        // Random keys and ghost pairs
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                i1 = $urandom_range(0, 15);
                i2 = (i1 + $urandom_range(1, 15)) % 16;
                mask[i1] = 1'b1; mask[i2] = 1'b1;
                wait_cyc(SCAN * $urandom_range(3, 6));
                mask = '0;
                wait_cyc(SCAN * 5);
            end else begin
                tap($urandom_range(0, 15));
            end
        end

        // Reach lockout, then reset in the middle of it
        for (int i = 0; i < LOCK + 10 && locked_out; i++) wait_cyc(1);
        chk("random_lock_cleared", locked_out, 1'b0);
        if (unlocked) type_str("D");
        type_str("*");
        for (int r = 0; r < MAXT; r++) begin
            type_str("9999");
            hold_hash(got);
            wait_cyc(3);
            if (locked_out) break;
            mask = '0;
            wait_cyc(SCAN * 6);
        end
        chk("pre_reset_locked", locked_out, 1'b1);
        wait_cyc(20);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_col", col, 4'b1110);
        chk("mid_rst_kv", key_valid, 1'b0);
        chk("mid_rst_kc", key_code, 4'h0);
        chk("mid_rst_digits", digits, 16'h0);
        chk("mid_rst_cnt", digit_cnt, 4'd0);
        chk("mid_rst_unlocked", unlocked, 1'b0);
        chk("mid_rst_locked", locked_out, 1'b0);
        chk("mid_rst_fail", fail, 1'b0);
        chk("mid_rst_saved", code_saved, 1'b0);
        mask = '0;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(SCAN * 4);
        type_str("1234#");
        chk("default_code_restored", unlocked, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
